// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester arbiter: sizes, FSM states and
// the code-to-one-hot decode used by both the picker and the top level.
package arb_pkg;

  localparam int NREQ    = 4;
  localparam int GCODE_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Code 1..4 maps to bit 1..4; code 0 (no owner) and unused codes map to zero.
  function automatic logic [NREQ:1] code_to_onehot(input logic [GCODE_W-1:0] code);
    logic [NREQ:1] oh;
    case (code)
      3'd1:    oh = 4'b0001;
      3'd2:    oh = 4'b0010;
      3'd3:    oh = 4'b0100;
      3'd4:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational winner selection: masks out the excluded requester, then
// either rotates the search to begin at 'start' (round-robin) or takes the
// highest set index (fixed priority). Returns code 0 when nothing remains.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NREQ:1]        req,
  input  logic [GCODE_W-1:0]   start,
  input  logic [GCODE_W-1:0]   exclude,
  input  logic                 rr_en,
  output logic [GCODE_W-1:0]   win
);

  logic [NREQ-1:0] masked;
  logic [1:0]      pos;

  // Priority search; later loop iterations override earlier ones, so the
  // iteration order encodes the priority order.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, otherwise
    // paths that skip an assignment would infer a latch.
    masked = req & ~code_to_onehot(exclude);
    win    = '0;
    pos    = '0;
    if (rr_en) begin
      // Walk offsets from farthest to nearest so the position closest to
      // 'start' (offset 0) is written last and wins. Wrap is 4 -> 1.
      for (int k = NREQ - 1; k >= 0; k--) begin
        pos = 2'(start - 3'd1) + 2'(k);
        if (masked[pos]) win = {1'b0, pos} + 3'd1;
      end
    end else begin
      // Ascending scan: the highest set index is written last and wins.
      for (int i = 0; i < NREQ; i++) begin
        if (masked[i]) win = 3'(i + 1);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester arbiter with fixed-priority or round-robin selection,
// grant hold while the owner keeps requesting, and a forced hand-off after
// MAX_HOLD cycles when another requester is waiting. gcode drives the
// downstream resource mux; all outputs are registered.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ:1]        req,
  input  logic                 rr_en,
  output logic [NREQ:1]        gnt,
  output logic [GCODE_W-1:0]   gcode,
  output logic                 busy,
  output logic                 expire
);

  localparam int              HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);

  state_t               state, state_n;
  logic [GCODE_W-1:0]   ptr, ptr_n;
  logic [GCODE_W-1:0]   code_n;
  logic [GCODE_W-1:0]   start;
  logic [GCODE_W-1:0]   win;
  logic [HW-1:0]        hcnt, hcnt_n;
  logic                 expire_n;
  logic [NREQ:1]        own_oh;
  logic                 own_req;
  logic                 others;

  // The owner is always excluded from the pick: on release its request is
  // already low, and on a forced hand-off it must not win again. In IDLE
  // gcode is 0, so nothing is excluded.
  assign own_oh  = code_to_onehot(gcode);
  assign own_req = |(req & own_oh);
  assign others  = |(req & ~own_oh);
  assign start   = (ptr == 3'(NREQ)) ? 3'd1 : ptr + 3'd1;

  rr_pick4 u_pick (
    .req     (req),
    .start   (start),
    .exclude (gcode),
    .rr_en   (rr_en),
    .win     (win)
  );

  // Next-state decision: new grant, forced hand-off, retain, or go idle.
  always_comb begin
    state_n  = state;
    code_n   = gcode;
    ptr_n    = ptr;
    hcnt_n   = hcnt;
    expire_n = 1'b0;
    case (state)
      IDLE: begin
        if (req != '0) begin
          state_n = GRANT;
          code_n  = win;
          ptr_n   = win;
          hcnt_n  = HW'(1);
        end
      end
      GRANT: begin
        if (!own_req) begin
          // Release: hand straight to the next winner, no bubble cycle.
          if (others) begin
            code_n = win;
            ptr_n  = win;
            hcnt_n = HW'(1);
          end else begin
            state_n = IDLE;
            code_n  = '0;
            hcnt_n  = '0;
          end
        end else if (hcnt == HOLD_MAX && others) begin
          // Hold budget spent while someone waits: rotate away from owner.
          code_n   = win;
          ptr_n    = win;
          hcnt_n   = HW'(1);
          expire_n = 1'b1;
        end else if (hcnt != HOLD_MAX) begin
          hcnt_n = hcnt + HW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        code_n  = '0;
        hcnt_n  = '0;
      end
    endcase
  end

  // State, pointer, hold counter and output registers; synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state  <= IDLE;
      gcode  <= '0;
      gnt    <= '0;
      busy   <= 1'b0;
      expire <= 1'b0;
      hcnt   <= '0;
      ptr    <= 3'(NREQ);
    end else begin
      state  <= state_n;
      gcode  <= code_n;
      gnt    <= code_to_onehot(code_n);
      busy   <= (code_n != '0);
      expire <= expire_n;
      hcnt   <= hcnt_n;
      ptr    <= ptr_n;
    end
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester arbiter that shares one downstream resource between requesters `req[4:1]`. It uses the same index convention as the team's 4-input priority encoder: bit 4 is the highest fixed priority, and the encoded code 0 means "none". It supports fixed-priority or round-robin selection, holds the grant while the owner keeps requesting, and forces a hand-off after `MAX_HOLD` cycles when another requester is waiting. It sits between the requester blocks and the shared resource mux, which is driven by `gcode`.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per owner while others wait. Must be ≥ 1.
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  [4:1]: request lines, level-sensitive; a requester holds its line high until done.
- `rr_en`  in  1: 1 selects round-robin, 0 selects fixed priority (4 > 3 > 2 > 1).
- `gnt`  out  [4:1]: one-hot or zero grant, registered.
- `gcode`  out  [2:0]: encoded owner, 3'd1..3'd4, or 3'd0 when there is no owner. Registered.
- `busy`  out  1: high while any grant is active, registered.
- `expire`  out  1: one-cycle pulse on the cycle a forced hand-off takes effect.

## Operation
- States are IDLE (no owner) and GRANT (owner held in `gcode`).
- IDLE → GRANT when `req != 0` at an edge; the winner is loaded at that edge.
- GRANT → IDLE when the owner's `req` bit is low and no other request is present.
- Owner release with other requests pending: the new winner is chosen from the remaining requests and loaded at the same edge. There is no bubble cycle.
- Fixed priority (`rr_en=0`): the highest set index wins.
- Round-robin (`rr_en=1`): the search starts at `ptr+1` and wraps 4 → 1. `ptr` is the last granted index and updates on every new grant. `ptr` resets to 4, so the first round-robin search starts at 1.
- Hold counter `hcnt`:
  - Width is $clog2(MAX_HOLD+1).
  - Loads 1 on every new grant and increments each cycle the same owner is retained.
  - Saturates at `MAX_HOLD`.
- Forced hand-off: when `hcnt == MAX_HOLD`, the owner still requests, and any other `req` bit is set, the grant moves at the next edge. The winner is chosen by the active mode with the current owner excluded, and `expire` is 1 for that cycle. In fixed-priority mode this still rotates away from the owner, so low priorities cannot starve forever under a top-priority hog.
- No other requester: the owner keeps the grant indefinitely and `hcnt` stays saturated. `expire` stays 0.
- Release coinciding with expiry: treated as a release, so `expire` = 0.
- `rr_en` change mid-grant: takes effect at the next arbitration decision. The current owner is not disturbed.
- Requests that drop before being granted are simply not considered; nothing is latched.

## Timing
- Reset values: `gnt`=0, `gcode`=0, `busy`=0, `expire`=0, `hcnt`=0, `ptr`=4, state IDLE.
- Reset asserted mid-grant clears everything at that edge. Requests present while `reset` is high are ignored.
- Latency: `req` sampled at edge N; `gnt`, `gcode` and `busy` are valid after edge N (one cycle).
- Release: owner `req` low before edge N means `gnt` changes after edge N.
- Invariants: `gnt` is always zero or one-hot, `gcode` always matches `gnt`, and `busy == |gnt`.

## Structure
- Shared package `arb_pkg` holds:
  - `NREQ=4`, `GCODE_W=3`;
  - the state enum {IDLE, GRANT};
  - a `code_to_onehot` function.
- Sub-module `rr_pick4` (combinational) takes `req[4:1]`, `start[2:0]`, `exclude[2:0]` and `rr_en`, and returns the winner code. It does the rotate plus priority-encode, with 4 highest when `rr_en=0`.
- Top level holds the state register, `ptr`, `hcnt` and the output registers.

## Test plan
- Reset, then `req=4'b0000` for 5 cycles → `gnt`=0, `gcode`=0, `busy`=0 throughout. Assert `reset` during a grant → all outputs 0 after that edge.
- `rr_en=0`, `req=4'b1011` → `gnt=4'b1000`, `gcode=3'd4` one cycle later. Drop `req[4]` → next edge `gcode=3'd2`, no idle cycle.
- `rr_en=1`, `req=4'b1111`, each owner releases after 1 cycle → `gcode` sequence 1, 2, 3, 4, 1.
- `MAX_HOLD=3`, `rr_en=1`, `req[1]` held, `req[3]` raised → owner 1 for 3 cycles, then `gcode=3'd3` with `expire=1` for exactly one cycle. `req[1]` alone held 20 cycles → no `expire`.
- Owner release on the same edge as expiry → `expire=0` and the new grant follows the normal rule. Toggle `rr_en` mid-grant → owner unchanged and the next decision uses the new mode.
- Random `req` for 10k cycles, checked against a reference model: `gnt` one-hot or zero, `gcode` matches `gnt`, and no waiting requester goes more than 3·`MAX_HOLD`+3 cycles without a grant.
